// File: rtl/xy_arb_pkg.sv
// Shared types and constants for the XY router output-port arbiter.
package xy_arb_pkg;

  // Arbiter state: waiting for a head flit, or locked onto one packet.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Input channel indices as seen by every output port.
  localparam int unsigned LOCAL = 0;
  localparam int unsigned NORTH = 1;
  localparam int unsigned EAST  = 2;
  localparam int unsigned SOUTH = 3;
  localparam int unsigned WEST  = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set bit of req_i scanning upward from
// ptr_i with wrap-around. Purely combinational.
module rr_priority_picker #(
  parameter int unsigned CHANNEL_NUMBER = 5,
  parameter int unsigned CHANNEL_WIDTH  = $clog2(CHANNEL_NUMBER)
) (
  input  logic [CHANNEL_NUMBER-1:0] req_i,
  input  logic [CHANNEL_WIDTH-1:0]  ptr_i,
  output logic [CHANNEL_NUMBER-1:0] pick_o,
  output logic [CHANNEL_WIDTH-1:0]  idx_o,
  output logic                      found_o
);

  logic [CHANNEL_NUMBER-1:0] onehot;
  int unsigned               pos;

  // Walk the channels in rotated order and keep the first requester.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    found_o = 1'b0;
    onehot  = '0;
    pos     = 0;
    for (int unsigned off = 0; off < CHANNEL_NUMBER; off++) begin
      pos = 32'(ptr_i) + off;
      if (pos >= CHANNEL_NUMBER) begin
        pos = pos - CHANNEL_NUMBER;
      end
      onehot = {{(CHANNEL_NUMBER-1){1'b0}}, 1'b1} << pos;
      if (!found_o && |(req_i & onehot)) begin
        found_o = 1'b1;
        pick_o  = onehot;
        idx_o   = CHANNEL_WIDTH'(pos);
      end
    end
  end

endmodule

// File: rtl/xy_output_port_arbiter.sv
// Per-output-port wormhole arbiter for the XY cross router. Grants one input
// round-robin, holds the grant until that input's last beat transfers, and
// hands over to the next requester on the same edge.
// Optional stall watchdog enabled by defining XY_ARB_WATCHDOG_EN.
module xy_output_port_arbiter
  import xy_arb_pkg::*;
#(
  parameter int unsigned CHANNEL_NUMBER  = 5,
  parameter int unsigned CHANNEL_WIDTH   = $clog2(CHANNEL_NUMBER),
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [CHANNEL_NUMBER-1:0] req_i,
  input  logic [CHANNEL_NUMBER-1:0] valid_i,
  input  logic [CHANNEL_NUMBER-1:0] last_i,
  input  logic                      out_ready_i,
  output logic [CHANNEL_NUMBER-1:0] grant_o,
  output logic [CHANNEL_WIDTH-1:0]  grant_idx_o,
  output logic                      grant_valid_o,
  output logic [CHANNEL_NUMBER-1:0] in_ready_o,
  output logic                      out_valid_o,
  output logic                      watchdog_o
);

  arb_state_e                state_q;
  logic [CHANNEL_NUMBER-1:0] grant_q;
  logic [CHANNEL_WIDTH-1:0]  grant_idx_q;
  logic                      grant_valid_q;
  logic [CHANNEL_WIDTH-1:0]  ptr_q;

  logic                      transfer;
  logic                      release_beat;
  logic [CHANNEL_WIDTH-1:0]  next_ptr;
  logic [CHANNEL_NUMBER-1:0] pick_req;
  logic [CHANNEL_WIDTH-1:0]  pick_ptr;
  logic [CHANNEL_NUMBER-1:0] pick;
  logic [CHANNEL_WIDTH-1:0]  pick_idx;
  logic                      pick_found;

  // A beat of the granted input moves downstream this cycle.
  assign transfer     = (state_q == LOCKED) & |(valid_i & grant_q) & out_ready_i;
  assign release_beat = transfer & |(last_i & grant_q);

  // Pointer just past the current owner, wrapped explicitly (non power-of-two count).
  always_comb begin
    if (grant_idx_q == CHANNEL_WIDTH'(CHANNEL_NUMBER - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx_q + 1'b1;
    end
  end

  // Picker sees raw requests when idle; on release the owner is masked out so
  // it cannot win its own release edge.
  always_comb begin
    if (state_q == LOCKED) begin
      pick_req = req_i & ~grant_q;
      pick_ptr = next_ptr;
    end else begin
      pick_req = req_i;
      pick_ptr = ptr_q;
    end
  end

  rr_priority_picker #(
    .CHANNEL_NUMBER (CHANNEL_NUMBER),
    .CHANNEL_WIDTH  (CHANNEL_WIDTH)
  ) u_picker (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_idx_q   <= CHANNEL_WIDTH'(LOCAL);
      grant_valid_q <= 1'b0;
      ptr_q         <= CHANNEL_WIDTH'(LOCAL);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q       <= LOCKED;
            grant_q       <= pick;
            grant_idx_q   <= pick_idx;
            grant_valid_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (release_beat) begin
            ptr_q <= next_ptr;
            if (pick_found) begin
              grant_q     <= pick;
              grant_idx_q <= pick_idx;
            end else begin
              state_q       <= IDLE;
              grant_q       <= '0;
              grant_idx_q   <= '0;
              grant_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = grant_valid_q;
  assign in_ready_o    = grant_q & {CHANNEL_NUMBER{out_ready_i}};
  assign out_valid_o   = grant_valid_q & |(valid_i & grant_q);

`ifdef XY_ARB_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q;
  logic           wd_pulse_q;

  // Count stalled LOCKED cycles; pulse and restart at the threshold. Grant untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_cnt_q   <= '0;
      wd_pulse_q <= 1'b0;
    end else if (state_q != LOCKED || transfer) begin
      wd_cnt_q   <= '0;
      wd_pulse_q <= 1'b0;
    end else if (wd_cnt_q == WdW'(WATCHDOG_CYCLES - 1)) begin
      wd_cnt_q   <= '0;
      wd_pulse_q <= 1'b1;
    end else begin
      wd_cnt_q   <= wd_cnt_q + 1'b1;
      wd_pulse_q <= 1'b0;
    end
  end

  assign watchdog_o = wd_pulse_q;
`else
  // Constant zero; the threshold is referenced only to keep it bound in this build.
  assign watchdog_o = 1'b0 & (WATCHDOG_CYCLES >= 2);
`endif

endmodule

// File: tb/tb_xy_output_port_arbiter.sv
// Self-checking bench for xy_output_port_arbiter: packet-level reference model
// compared every cycle, plus directed literal checks.
module tb_xy_output_port_arbiter;

  localparam int unsigned N  = 5;
  localparam int unsigned W  = 3;
  localparam int unsigned WD = 8;
`ifdef XY_ARB_WATCHDOG_EN
  localparam bit WdOn = 1'b1;
`else
  localparam bit WdOn = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] valid;
  logic [N-1:0] last;
  logic         ordy;
  logic [N-1:0] grant;
  logic [W-1:0] grant_idx;
  logic         grant_valid;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic         wdog;

  int checks   = 0;
  int failures = 0;

  // Reference model state (packet level)
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_stall  = 0;
  bit m_wd     = 1'b0;

  xy_output_port_arbiter #(
    .CHANNEL_NUMBER  (N),
    .CHANNEL_WIDTH   (W),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_i         (req),
    .valid_i       (valid),
    .last_i        (last),
    .out_ready_i   (ordy),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid),
    .in_ready_o    (in_ready),
    .out_valid_o   (out_valid),
    .watchdog_o    (wdog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int off = 0; off < N; off++) begin
      int k;
      k = (p + off) % N;
      if (m[k]) return k;
    end
    return -1;
  endfunction

  // Model: advance one packet-level step per clock edge, reset asynchronously.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_stall = 0; m_wd = 1'b0;
      end else begin
        bit           xfer;
        int           k;
        logic [N-1:0] mask;
        xfer = m_locked && valid[m_owner] && ordy;
        if (WdOn && m_locked && !xfer) begin
          m_stall++;
          if (m_stall == WD) begin
            m_wd = 1'b1; m_stall = 0;
          end else begin
            m_wd = 1'b0;
          end
        end else begin
          m_stall = 0; m_wd = 1'b0;
        end
        if (!m_locked) begin
          k = rr_pick(req, m_ptr);
          if (k >= 0) begin
            m_locked = 1'b1; m_owner = k;
          end
        end else if (xfer && last[m_owner]) begin
          m_ptr = (m_owner + 1) % N;
          mask = req;
          mask[m_owner] = 1'b0;
          k = rr_pick(mask, m_ptr);
          if (k >= 0) begin
            m_owner = k;
          end else begin
            m_locked = 1'b0; m_owner = 0;
          end
        end
      end
    end
  end

  // Compare every cycle, mid-period, against the model.
  initial begin
    forever begin
      logic [N-1:0] eg;
      @(negedge clk);
      #1;
      eg = '0;
      if (m_locked) eg[m_owner] = 1'b1;
      chk("grant", 32'(grant), 32'(eg));
      chk("grant_idx", 32'(grant_idx), m_locked ? m_owner : 0);
      chk("grant_valid", 32'(grant_valid), 32'(m_locked));
      chk("in_ready", 32'(in_ready), 32'(eg & {N{ordy}}));
      chk("out_valid", 32'(out_valid), 32'(m_locked && valid[m_owner]));
      chk("watchdog", 32'(wdog), 32'(m_wd));
    end
  end

  // Apply one cycle of inputs, then look just after the edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] v,
                      input logic [N-1:0] l, input logic o);
    req = r; valid = v; last = l; ordy = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int exp_order[6];
    exp_order = '{3, 4, 0, 1, 2, 3};
    rst_n = 1'b0; req = '0; valid = '0; last = '0; ordy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_gv", 32'(grant_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, single-beat packet
    step(5'b00100, 5'b00000, 5'b00000, 1'b1);
    chk("t1_grant", 32'(grant), 32'b00100);
    chk("t1_idx", 32'(grant_idx), 2);
    step(5'b00000, 5'b00100, 5'b00100, 1'b1);
    chk("t1_release", 32'(grant_valid), 0);
    chk("t1_grant0", 32'(grant), 0);

    // All request, 1-beat packets: pointer started at 3
    for (int i = 0; i < 6; i++) begin
      step(5'b11111, 5'b11111, 5'b11111, 1'b1);
      chk("t2_order", 32'(grant_idx), exp_order[i]);
      chk("t2_gv", 32'(grant_valid), 1);
    end
    step(5'b00000, 5'b11111, 5'b11111, 1'b1);
    chk("t2_drain", 32'(grant_valid), 0);

    // 4-beat packet on input 1 with ready toggling and req[0] withdrawn
    step(5'b00010, 5'b00000, 5'b00000, 1'b1);
    chk("t3_grant", 32'(grant_idx), 1);
    step(5'b00011, 5'b11111, 5'b00000, 1'b1);
    chk("t3_b1", 32'(grant), 32'b00010);
    step(5'b00011, 5'b11111, 5'b00000, 1'b0);
    chk("t3_s1", 32'(grant), 32'b00010);
    step(5'b00011, 5'b11111, 5'b00000, 1'b1);
    chk("t3_b2", 32'(grant), 32'b00010);
    step(5'b00010, 5'b11111, 5'b00000, 1'b0);
    chk("t3_s2", 32'(grant), 32'b00010);
    step(5'b00010, 5'b11111, 5'b00000, 1'b1);
    chk("t3_b3", 32'(grant), 32'b00010);
    step(5'b00000, 5'b11111, 5'b00010, 1'b0);
    chk("t3_last_stalled", 32'(grant), 32'b00010);
    step(5'b00000, 5'b11111, 5'b00010, 1'b1);
    chk("t3_b4_release", 32'(grant_valid), 0);

    // Handover from 4 wraps to 0, 4 not re-granted
    step(5'b10000, 5'b00000, 5'b00000, 1'b1);
    chk("t4_grant4", 32'(grant_idx), 4);
    step(5'b10001, 5'b10000, 5'b10000, 1'b1);
    chk("t4_handover", 32'(grant), 32'b00001);
    chk("t4_gv", 32'(grant_valid), 1);
    step(5'b00000, 5'b00001, 5'b00001, 1'b1);
    chk("t4_idle", 32'(grant_valid), 0);

    // Sole requester cannot win its own release edge
    step(5'b00100, 5'b00000, 5'b00000, 1'b1);
    chk("t5_grant2", 32'(grant_idx), 2);
    step(5'b00100, 5'b00100, 5'b00100, 1'b1);
    chk("t5_bubble", 32'(grant_valid), 0);
    step(5'b00100, 5'b00000, 5'b00000, 1'b1);
    chk("t5_regrant", 32'(grant), 32'b00100);
    step(5'b00000, 5'b00100, 5'b00100, 1'b1);

    // Asynchronous reset mid-packet on input 3
    step(5'b01000, 5'b00000, 5'b00000, 1'b1);
    chk("t6_grant3", 32'(grant_idx), 3);
    step(5'b00000, 5'b01000, 5'b00000, 1'b1);
    chk("t6_mid", 32'(grant), 32'b01000);
    #2;
    rst_n = 1'b0;
    req = '0; valid = '0; last = '0;
    #1;
    chk("t6_async_grant", 32'(grant), 0);
    chk("t6_async_gv", 32'(grant_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(5'b01000, 5'b00000, 5'b00000, 1'b1);
    chk("t6_regrant", 32'(grant), 32'b01000);

    // Long stall on input 3
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(5'b00000, 5'b01000, 5'b00000, 1'b0);
      if (wdog) pulses++;
    end
    chk("t7_pulses", pulses, WdOn ? 2 : 0);
    chk("t7_grant_held", 32'(grant), 32'b01000);

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
